// File: rtl/ascii_load_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ascii_load_sequencer
// Description : Paces "Load Ascii" download bytes into the UK101 ACIA receive
//               path as 8N1 serial frames. Download bytes are buffered in a
//               small FIFO, line feeds are stripped, and a long idle gap is
//               inserted after every carriage return so BASIC / monitor line
//               entry can keep up. The ACIA RX line is multiplexed between
//               this injector and the physical UART pin under loadFrom.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             in   1  system clock (50 MHz)
//   n_reset         in   1  asynchronous active-low reset
//   loadFrom        in   1  0 = file injection owns RX line, 1 = UART pin
//   baud_rate       in   1  0 = fast divider, 1 = slow divider
//   ioctl_download  in   1  download in progress
//   ioctl_wr        in   1  one-cycle byte strobe
//   ioctl_data      in   8  download byte
//   ioctl_wait      out  1  registered backpressure towards hps_io
//   rxd             in   1  physical UART_RXD
//   ser_rxd         out  1  registered serial line into the ACIA
//   busy            out  1  registered: frame in flight or bytes queued
//   overflow        out  1  sticky: a byte was dropped on a full FIFO
// ============================================================================
module ascii_load_sequencer #(
  parameter int FIFO_DEPTH    = 16,
  parameter int BAUD_DIV_FAST = 5208,
  parameter int BAUD_DIV_SLOW = 166667,
  parameter int CHAR_GAP_BITS = 2,
  parameter int CR_GAP_BITS   = 960
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       loadFrom,
  input  logic       baud_rate,
  input  logic       ioctl_download,
  input  logic       ioctl_wr,
  input  logic [7:0] ioctl_data,
  output logic       ioctl_wait,
  input  logic       rxd,
  output logic       ser_rxd,
  output logic       busy,
  output logic       overflow
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W   = c_PTR_W + 1;
  // 18 bits covers the 300 baud divider at 50 MHz (166667 < 2^18).
  localparam int c_TMR_W   = 18;
  localparam int c_GAP_MAX = (CR_GAP_BITS > CHAR_GAP_BITS) ? CR_GAP_BITS : CHAR_GAP_BITS;
  localparam int c_GAP_W   = (c_GAP_MAX < 1) ? 1 : $clog2(c_GAP_MAX + 1);

  localparam logic [c_TMR_W-1:0] c_DIV_FAST_M1 = c_TMR_W'(BAUD_DIV_FAST - 1);
  localparam logic [c_TMR_W-1:0] c_DIV_SLOW_M1 = c_TMR_W'(BAUD_DIV_SLOW - 1);
  localparam logic [c_GAP_W-1:0] c_GAP_CHAR    = c_GAP_W'(CHAR_GAP_BITS);
  localparam logic [c_GAP_W-1:0] c_GAP_CR      = c_GAP_W'(CR_GAP_BITS);
  localparam logic [c_CNT_W-1:0] c_CNT_FULL    = c_CNT_W'(FIFO_DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_WAIT    = c_CNT_W'(FIFO_DEPTH - 1);

  localparam logic [7:0] c_CHAR_LF = 8'h0A;
  localparam logic [7:0] c_CHAR_CR = 8'h0D;

  // Frame state machine encoding
  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_START = 3'd1;
  localparam logic [2:0] c_ST_DATA  = 3'd2;
  localparam logic [2:0] c_ST_STOP  = 3'd3;
  localparam logic [2:0] c_ST_GAP   = 3'd4;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_wait;
  logic               r_overflow;

  logic [2:0]         r_state;
  logic [c_TMR_W-1:0] r_timer;
  logic [c_TMR_W-1:0] r_div_m1;
  logic [7:0]         r_shift;
  logic [2:0]         r_bit_idx;
  logic               r_is_cr;
  logic [c_GAP_W-1:0] r_gap_cnt;

  logic               r_ser_rxd;
  logic               r_busy;

  logic               w_fifo_empty;
  logic               w_fifo_full;
  logic               w_wr_req;
  logic               w_push;
  logic               w_drop;
  logic               w_pop;
  logic [c_CNT_W-1:0] w_count_next;
  logic               w_bit_done;
  logic [c_TMR_W-1:0] w_div_sel_m1;
  logic [c_GAP_W-1:0] w_gap_len;
  logic               w_line;

  // --------------------------------------------------------------------------
  // FIFO control
  // --------------------------------------------------------------------------
  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == c_CNT_FULL);

  // Line feeds are filtered at the door: the UK101 treats CR as end-of-line
  // and an extra LF would appear as a stray keystroke.
  assign w_wr_req = ioctl_download & ioctl_wr & ~loadFrom & (ioctl_data != c_CHAR_LF);
  assign w_push   = w_wr_req & ~w_fifo_full;
  assign w_drop   = w_wr_req &  w_fifo_full;
  assign w_pop    = (r_state == c_ST_IDLE) & ~w_fifo_empty & ~loadFrom;

  always_comb begin
    w_count_next = r_count;
    if (loadFrom) begin
      w_count_next = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_next = r_count + c_CNT_W'(1);
        2'b01:   w_count_next = r_count - c_CNT_W'(1);
        default: w_count_next = r_count;
      endcase
    end
  end

  // Storage has no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= ioctl_data;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_wait     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      // Asserting one entry early leaves room for a write already in flight
      // when hps_io sees the wait.
      r_wait <= (w_count_next >= c_CNT_WAIT);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (loadFrom) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        end
      end
      r_count <= w_count_next;
    end
  end

  // --------------------------------------------------------------------------
  // Frame sequencer
  // --------------------------------------------------------------------------
  assign w_bit_done   = (r_timer == '0);
  assign w_div_sel_m1 = baud_rate ? c_DIV_SLOW_M1 : c_DIV_FAST_M1;
  assign w_gap_len    = r_is_cr ? c_GAP_CR : c_GAP_CHAR;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state   <= c_ST_IDLE;
      r_timer   <= '0;
      r_div_m1  <= c_DIV_FAST_M1;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_is_cr   <= 1'b0;
      r_gap_cnt <= '0;
    end else if (loadFrom) begin
      // Handing the line to the UART pin abandons any partial frame.
      r_state <= c_ST_IDLE;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_pop) begin
            r_shift  <= r_mem[r_rd_ptr];
            r_is_cr  <= (r_mem[r_rd_ptr] == c_CHAR_CR);
            // Divider is frozen for the whole frame; a baud change only
            // affects the next frame.
            r_div_m1 <= w_div_sel_m1;
            r_timer  <= w_div_sel_m1;
            r_state  <= c_ST_START;
          end
        end

        c_ST_START: begin
          if (w_bit_done) begin
            r_timer   <= r_div_m1;
            r_bit_idx <= '0;
            r_state   <= c_ST_DATA;
          end else begin
            r_timer <= r_timer - c_TMR_W'(1);
          end
        end

        c_ST_DATA: begin
          if (w_bit_done) begin
            r_timer <= r_div_m1;
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_state <= c_ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_timer <= r_timer - c_TMR_W'(1);
          end
        end

        c_ST_STOP: begin
          if (w_bit_done) begin
            r_timer <= r_div_m1;
            if (w_gap_len == '0) begin
              r_state <= c_ST_IDLE;
            end else begin
              // Gap counter holds remaining bit-times minus one.
              r_gap_cnt <= w_gap_len - c_GAP_W'(1);
              r_state   <= c_ST_GAP;
            end
          end else begin
            r_timer <= r_timer - c_TMR_W'(1);
          end
        end

        c_ST_GAP: begin
          if (w_bit_done) begin
            if (r_gap_cnt == '0) begin
              r_state <= c_ST_IDLE;
            end else begin
              r_gap_cnt <= r_gap_cnt - c_GAP_W'(1);
              r_timer   <= r_div_m1;
            end
          end else begin
            r_timer <= r_timer - c_TMR_W'(1);
          end
        end

        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Line mux and status outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_line = 1'b1;
    case (r_state)
      c_ST_START: w_line = 1'b0;
      c_ST_DATA:  w_line = r_shift[0];
      default:    w_line = 1'b1;
    endcase
  end

  // Both outputs are registered; busy therefore trails the sequencer by a
  // cycle, so it drops one cycle after the state/FIFO go quiet.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_ser_rxd <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_ser_rxd <= loadFrom ? rxd : w_line;
      r_busy    <= (r_state != c_ST_IDLE) | ~w_fifo_empty;
    end
  end

  assign ser_rxd    = r_ser_rxd;
  assign busy       = r_busy;
  assign ioctl_wait = r_wait;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ascii_load_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ascii_load_sequencer
// Description : Directed self-checking bench for ascii_load_sequencer. Uses
//               shortened dividers and gaps so full frames fit a short run.
//               A background line monitor decodes 8N1 frames (start time,
//               first rising edge, data byte) into a queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ascii_load_sequencer;

  localparam int FD   = 16;
  localparam int FAST = 4;
  localparam int SLOW = 12;
  localparam int CG   = 2;
  localparam int CRG  = 6;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       loadFrom = 1'b0;
  logic       baud_rate = 1'b0;
  logic       ioctl_download = 1'b0;
  logic       ioctl_wr = 1'b0;
  logic [7:0] ioctl_data = 8'h00;
  logic       rxd = 1'b1;
  logic       ioctl_wait;
  logic       ser_rxd;
  logic       busy;
  logic       overflow;

  ascii_load_sequencer #(
    .FIFO_DEPTH    (FD),
    .BAUD_DIV_FAST (FAST),
    .BAUD_DIV_SLOW (SLOW),
    .CHAR_GAP_BITS (CG),
    .CR_GAP_BITS   (CRG)
  ) dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .loadFrom       (loadFrom),
    .baud_rate      (baud_rate),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_data     (ioctl_data),
    .ioctl_wait     (ioctl_wait),
    .rxd            (rxd),
    .ser_rxd        (ser_rxd),
    .busy           (busy),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    int         st;
    int         rise;
    logic       ok;
  } frame_t;

  frame_t frames[$];
  int     mon_div = FAST;
  bit     mon_en  = 1'b1;

  int checks = 0;
  int errors = 0;

  // Line monitor: samples each bit at its centre relative to the first low.
  always begin
    @(negedge clk);
    if (mon_en && n_reset && ser_rxd === 1'b0) begin : mon_frame
      int         d;
      int         st;
      int         rise;
      logic [9:0] fr;
      frame_t     f;
      d    = mon_div;
      st   = cyc;
      rise = -1;
      fr   = '0;
      for (int k = 1; k < 10 * d; k++) begin
        @(negedge clk);
        if (rise < 0 && ser_rxd === 1'b1) rise = k;
        if ((k % d) == d / 2) fr[k / d] = ser_rxd;
      end
      f.b    = fr[8:1];
      f.st   = st;
      f.rise = rise;
      f.ok   = (fr[0] === 1'b0) && (fr[9] === 1'b1);
      frames.push_back(f);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] d);
    @(negedge clk);
    ioctl_wr   = 1'b1;
    ioctl_data = d;
  endtask

  task automatic end_write();
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    int k = 0;
    while (frames.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, (frames.size() >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_low(input int budget, input string tag);
    int k = 0;
    while (ser_rxd !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'd0, ser_rxd}, 32'd0);
  endtask

  initial begin : stim
    int          bf;
    int          k;
    int          sent;
    int          seen_at;
    int          bad;
    int          lows;
    int          busy_hi;
    logic [3:0]  pat;
    logic        prev;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_ser_rxd",    {31'd0, ser_rxd},    32'd1);
    check("rst_busy",       {31'd0, busy},       32'd0);
    check("rst_ioctl_wait", {31'd0, ioctl_wait}, 32'd0);
    check("rst_overflow",   {31'd0, overflow},   32'd0);
    @(negedge clk);
    n_reset        = 1'b1;
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk);

    // ---------------- single byte 0x41, fast ----------------
    frames.delete();
    mon_div = FAST;
    write_byte(8'h41);
    end_write();
    @(negedge clk);
    check("t1_busy_on", {31'd0, busy}, 32'd1);
    bf = -1;
    k  = 0;
    while (bf < 0 && k < 200) begin
      @(negedge clk);
      k++;
      if (busy === 1'b0) bf = cyc;
    end
    check("t1_busy_fall_seen", (bf >= 0) ? 32'd1 : 32'd0, 32'd1);
    wait_frames(1, 100, "t1_frame_timeout");
    if (frames.size() >= 1) begin
      check("t1_byte",       {24'd0, frames[0].b},          32'h41);
      check("t1_framing",    {31'd0, frames[0].ok},         32'd1);
      check("t1_start_len",  frames[0].rise,                FAST);
      check("t1_busy_fall",  bf - frames[0].st,             12 * FAST);
    end

    // ---------------- LF filter and CR pacing ----------------
    frames.delete();
    write_byte(8'h31);
    write_byte(8'h0D);
    write_byte(8'h0A);
    write_byte(8'h32);
    end_write();
    wait_idle(1000, "t2_idle_timeout");
    repeat (20) @(negedge clk);
    check("t2_frame_count", frames.size(), 3);
    if (frames.size() == 3) begin
      check("t2_byte0",  {24'd0, frames[0].b}, 32'h31);
      check("t2_byte1",  {24'd0, frames[1].b}, 32'h0D);
      check("t2_byte2",  {24'd0, frames[2].b}, 32'h32);
      check("t2_char_interval", frames[1].st - frames[0].st, (10 + CG) * FAST + 1);
      check("t2_cr_interval",   frames[2].st - frames[1].st, (10 + CRG) * FAST + 1);
    end

    // ---------------- backpressure honoured ----------------
    frames.delete();
    sent    = 0;
    seen_at = -1;
    k       = 0;
    while (sent < 20 && k < 3000) begin
      @(negedge clk);
      k++;
      if (ioctl_wait === 1'b1 && seen_at < 0) seen_at = sent;
      if (ioctl_wait === 1'b0) begin
        ioctl_wr   = 1'b1;
        ioctl_data = 8'h60 + 8'(sent);
        sent++;
      end else begin
        ioctl_wr = 1'b0;
      end
    end
    end_write();
    check("t3_all_sent",  sent, 20);
    check("t3_wait_rise", seen_at, 16);
    wait_frames(20, 20 * 60 + 200, "t3_frame_timeout");
    wait_idle(200, "t3_idle_timeout");
    repeat (20) @(negedge clk);
    check("t3_overflow", {31'd0, overflow}, 32'd0);
    check("t3_frame_count", frames.size(), 20);
    bad = 0;
    for (int i = 0; i < frames.size() && i < 20; i++) begin
      if (frames[i].b !== 8'h60 + 8'(i) || frames[i].ok !== 1'b1) bad++;
    end
    check("t3_order", bad, 0);

    // ---------------- backpressure ignored ----------------
    frames.delete();
    for (int i = 0; i < 20; i++) write_byte(8'h40 + 8'(i));
    end_write();
    wait_idle(2000, "t4_idle_timeout");
    repeat (20) @(negedge clk);
    check("t4_overflow", {31'd0, overflow}, 32'd1);
    check("t4_frame_count", frames.size(), 17);
    bad = 0;
    for (int i = 0; i < frames.size() && i < 17; i++) begin
      if (frames[i].b !== 8'h40 + 8'(i) || frames[i].ok !== 1'b1) bad++;
    end
    check("t4_order", bad, 0);

    // ---------------- slow baud, mid-frame baud change ----------------
    frames.delete();
    mon_div   = SLOW;
    baud_rate = 1'b1;
    write_byte(8'h55);
    write_byte(8'h56);
    end_write();
    repeat (3 * SLOW) @(negedge clk);
    baud_rate = 1'b0;
    wait_frames(1, 20 * SLOW, "t5_frame0_timeout");
    mon_div = FAST;
    wait_frames(2, 20 * SLOW, "t5_frame1_timeout");
    wait_idle(200, "t5_idle_timeout");
    if (frames.size() >= 2) begin
      check("t5_byte0",      {24'd0, frames[0].b},  32'h55);
      check("t5_framing0",   {31'd0, frames[0].ok}, 32'd1);
      check("t5_slow_bit",   frames[0].rise,        SLOW);
      check("t5_byte1",      {24'd0, frames[1].b},  32'h56);
      check("t5_fast_bit",   frames[1].rise,        2 * FAST);
      check("t5_interval",   frames[1].st - frames[0].st, (10 + CG) * SLOW + 1);
    end

    // ---------------- source switch mid-frame ----------------
    mon_en = 1'b0;
    for (int i = 0; i < 6; i++) write_byte(8'h21 + 8'(i));
    end_write();
    wait_low(100, "t6_start_timeout");
    repeat (3 * FAST) @(negedge clk);
    loadFrom = 1'b1;
    rxd      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t6_busy_off",  {31'd0, busy},       32'd0);
    check("t6_wait_off",  {31'd0, ioctl_wait}, 32'd0);
    check("t6_line_rxd",  {31'd0, ser_rxd},    32'd1);
    pat  = 4'b0110;
    prev = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rxd = pat[i];
      check("t6_hold",   {31'd0, ser_rxd}, {31'd0, prev});
      @(negedge clk);
      check("t6_follow", {31'd0, ser_rxd}, {31'd0, pat[i]});
      prev = pat[i];
    end
    rxd      = 1'b1;
    loadFrom = 1'b0;
    lows     = 0;
    busy_hi  = 0;
    repeat (150) begin
      @(negedge clk);
      if (ser_rxd !== 1'b1) lows++;
      if (busy !== 1'b0) busy_hi++;
    end
    check("t6_no_emit", lows, 0);
    check("t6_no_busy", busy_hi, 0);
    mon_en = 1'b1;

    // ---------------- async reset mid-START ----------------
    check("t7_ovf_pre", {31'd0, overflow}, 32'd1);
    write_byte(8'h33);
    write_byte(8'h34);
    end_write();
    wait_low(100, "t7_start_timeout");
    @(negedge clk);
    #2;
    n_reset = 1'b0;
    #1;
    check("t7_ser_rxd",    {31'd0, ser_rxd},    32'd1);
    check("t7_busy",       {31'd0, busy},       32'd0);
    check("t7_ioctl_wait", {31'd0, ioctl_wait}, 32'd0);
    check("t7_overflow",   {31'd0, overflow},   32'd0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    lows    = 0;
    busy_hi = 0;
    repeat (300) begin
      @(negedge clk);
      if (ser_rxd !== 1'b1) lows++;
      if (busy !== 1'b0) busy_hi++;
    end
    check("t7_no_residual", lows, 0);
    check("t7_no_busy",     busy_hi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ascii_load_sequencer.md
Name: ascii_load_sequencer

Overview:
- Sequences "Load Ascii" file downloads into the UK101 serial receive path.
- Buffers ioctl bytes in a small FIFO and paces them out as 8N1 serial frames at the selected baud.
- Inserts an extra delay after each CR so BASIC/monitor line entry keeps up.
- Arbitrates the ACIA RX line between this injector and the physical UART_RXD pin, under control of loadFrom.

Parameters:
- FIFO_DEPTH, 16, byte FIFO entries (power of 2, ≥4)
- BAUD_DIV_FAST, 5208, clk cycles per bit at 9600 baud (50 MHz)
- BAUD_DIV_SLOW, 166667, clk cycles per bit at 300 baud
- CHAR_GAP_BITS, 2, idle bit-times after every stop bit
- CR_GAP_BITS, 960, idle bit-times after a 0x0D frame (replaces CHAR_GAP_BITS)

Ports:
- clk  in  1  system clock, 50 MHz
- n_reset  in  1  asynchronous active-low reset
- loadFrom  in  1  0 = file injection owns RX line, 1 = UART pin owns it
- baud_rate  in  1  0 = fast divider, 1 = slow divider
- ioctl_download  in  1  download active
- ioctl_wr  in  1  one-cycle byte strobe
- ioctl_data  in  8  download byte
- ioctl_wait  out  1  backpressure to hps_io
- rxd  in  1  physical UART_RXD
- ser_rxd  out  1  serial line into ACIA RX
- busy  out  1  injection in progress
- overflow  out  1  sticky: byte dropped on full FIFO

Behaviour:
- Reset (async, n_reset=0):
  - FIFO empty; FSM IDLE.
  - ser_rxd=1, ioctl_wait=0, busy=0, overflow=0.
- FIFO write:
  - Occurs when ioctl_download & ioctl_wr & !loadFrom.
  - Byte 0x0A is discarded and never enters the FIFO.
  - A write while the FIFO is full is dropped and sets overflow. overflow clears only on reset.
- ioctl_wait:
  - Registered.
  - 1 when FIFO count ≥ FIFO_DEPTH-1 after the current cycle's push/pop; else 0.
  - Guarantees room for one in-flight write.
- Bit timer:
  - 18-bit down-counter.
  - The divider is latched from baud_rate at the START entry of each frame; a mid-frame change takes effect at the next frame.
- FSM:
  - IDLE: if FIFO non-empty and !loadFrom, pop byte into shift register and go to START. Pop and push may coincide in one cycle; count stays unchanged.
  - START: line 0 for one bit-time, then DATA.
  - DATA: 8 bits, LSB first, one bit-time each, then STOP.
  - STOP: line 1 for one bit-time, then GAP with gap counter = CR_GAP_BITS if byte==0x0D else CHAR_GAP_BITS.
  - GAP: line 1 for that many bit-times, then IDLE.
  - Back-to-back: the next START begins on the cycle after GAP completes, plus one IDLE cycle.
- busy = FSM≠IDLE or FIFO non-empty. busy is independent of ioctl_download; the FIFO drains after download ends.
- ser_rxd:
  - Registered, one-cycle latency.
  - = rxd when loadFrom=1.
  - = FSM line value when loadFrom=0 (1 in IDLE/STOP/GAP).
- loadFrom rising:
  - FIFO flushed, FSM forced to IDLE in the same cycle, busy falls next cycle.
  - ser_rxd follows rxd from the next cycle.
  - A partial frame is abandoned. The ACIA sees a framing error, which is acceptable.
- A new download starting while the FIFO drains appends normally; no flush.
- Zero-length download: no effect.

Test Plan:
- Single byte, fast baud:
  - Stimulus: loadFrom=0, baud_rate=0, write 0x41.
  - ser_rxd low for 5208 cycles, then bits 1,0,0,0,0,0,1,0 at 5208 cycles each, stop high.
  - busy falls 2×5208 cycles after the stop bit ends.
- LF filter and CR pacing:
  - Stimulus: write 0x31,0x0D,0x0A,0x32.
  - Exactly three frames.
  - Gap between the end of the 0x0D stop bit and the 0x32 start bit = 960×5208 (+1) cycles.
  - 0x0A never appears on the line.
- Backpressure:
  - Stimulus: write 20 bytes back-to-back, honouring ioctl_wait.
  - ioctl_wait rises when count reaches 15, overflow stays 0, all 20 frames emitted in order.
  - Repeat ignoring ioctl_wait: overflow=1 and the dropped bytes are absent from the output.
- Slow baud and mid-frame baud change:
  - Stimulus: baud_rate=1, write 0x55; flip baud_rate to 0 during DATA.
  - Frame 0x55 completes at 166667 cycles/bit.
  - The next byte is sent at 5208 cycles/bit.
- Source switch:
  - Stimulus: during the DATA phase of a frame with 5 bytes queued, raise loadFrom.
  - Next cycle FSM is IDLE and FIFO is empty; busy=0 one cycle later.
  - ser_rxd tracks toggling rxd with one-cycle latency.
  - Lowering loadFrom again emits nothing.
- Async reset mid-operation:
  - Stimulus: assert n_reset low asynchronously mid-START.
  - ser_rxd=1, busy=0, ioctl_wait=0, overflow=0 immediately.
  - After release, no residual frame is emitted.
